// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one external W x W multiplier among N_REQ requesters.
// Operands are held for MUL_LAT cycles, then the product is registered and returned to its owner.
module booth_mult_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [2*W-1:0]     rsp_p,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_p,
  output logic               busy,
  output logic [15:0]        op_count
);
  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           r_state;
  logic [IdxW-1:0]  r_last;
  logic [IdxW-1:0]  r_owner;
  logic [CntW-1:0]  r_cnt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_rsp_p;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [15:0]      r_op_count;

  logic             w_found;
  logic [IdxW-1:0]  w_grant;

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin : p_pick
    int unsigned idx;
    logic [IdxW-1:0] cand;
    idx     = 0;
    cand    = '0;
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(r_last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IdxW'(idx);
      if (!w_found && req_valid[cand]) begin
        w_found = 1'b1;
        w_grant = cand;
      end
    end
  end

  assign req_ready = ((r_state == StIdle) && w_found) ? (N_REQ'(1) << w_grant) : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign busy      = (r_state != StIdle);
  assign op_count  = r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_last      <= IdxW'(N_REQ - 1);
      r_owner     <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_p     <= '0;
      r_rsp_valid <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_a     <= req_a[w_grant*W +: W];
            r_b     <= req_b[w_grant*W +: W];
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_cnt   <= CntW'(MUL_LAT - 1);
            r_state <= StWait;
          end
        end
        StWait: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CntW'(1);
          end else begin
            r_rsp_p     <= mul_p;
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomised self-checking bench for booth_mult_arbiter; a transaction-level model predicts
// round-robin grants and products, and a second instance exercises MUL_LAT=3.
module tb_booth_mult_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [15:0]    rsp_p, mul_p, op_count;
  logic [7:0]     mul_a, mul_b;
  logic           busy;

  logic [N-1:0]   d3_req_valid, d3_req_ready, d3_rsp_valid, d3_rsp_ready;
  logic [N*8-1:0] d3_req_a, d3_req_b;
  logic [15:0]    d3_rsp_p, d3_mul_p, d3_op_count;
  logic [7:0]     d3_mul_a, d3_mul_b;
  logic           d3_busy;

  assign mul_p    = 16'(mul_a) * 16'(mul_b);
  assign d3_mul_p = 16'(d3_mul_a) * 16'(d3_mul_b);

  booth_mult_arbiter #(.N_REQ(N), .W(8), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy), .op_count(op_count)
  );

  booth_mult_arbiter #(.N_REQ(N), .W(8), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(d3_req_valid), .req_a(d3_req_a), .req_b(d3_req_b),
    .req_ready(d3_req_ready), .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
    .rsp_p(d3_rsp_p), .mul_a(d3_mul_a), .mul_b(d3_mul_b), .mul_p(d3_mul_p), .busy(d3_busy),
    .op_count(d3_op_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = N - 1;
  int m_ops   = 0;

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
  endtask

  task automatic wait_grant(output bit to);
    #1;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready !== '0) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  // Drives one lone request through accept and response with rsp_ready held high.
  task automatic one_op(input int r, input logic [7:0] a, input logic [7:0] b,
                        output logic [N-1:0] rdy, output logic [N-1:0] rv,
                        output logic [15:0] p, output int lat, output bit to);
    set_req(r, a, b);
    req_valid = onehot(r);
    rsp_ready = '1;
    wait_grant(to);
    rdy = req_ready;
    rv  = '0;
    p   = '0;
    lat = 0;
    if (to) return;
    step();
    lat = 1;
    req_valid = '0;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid !== '0) begin
        to = 1'b0;
        break;
      end
      step();
      lat++;
    end
    rv = rsp_valid;
    p  = rsp_p;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
    d3_req_valid = '0; d3_req_a = '0; d3_req_b = '0; d3_rsp_ready = '1;
    step(); step();
    n_tests++;
    if ({req_ready, rsp_valid, rsp_p, mul_a, mul_b, busy, op_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b rv=%b p=%h a=%h b=%h busy=%b cnt=%h required all 0",
               req_ready, rsp_valid, rsp_p, mul_a, mul_b, busy, op_count);
    end
    rst = 1'b0;
    m_last = N - 1;
    m_ops  = 0;
    req_valid = 4'b1001;
    #1;
    n_tests++;
    if (req_ready !== onehot(pick(m_last, req_valid))) begin
      n_fail++;
      $display("FAIL reset_priority: got req_ready=%b required %b", req_ready,
               onehot(pick(m_last, req_valid)));
    end
    req_valid = '0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_request: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] rdy, rv;
    logic [15:0] p;
    int lat;
    bit to;
    one_op(0, 8'd13, 8'd11, rdy, rv, p, lat, to);
    m_last = 0;
    m_ops++;
    n_tests++;
    if (to || rdy !== 4'b0001 || rv !== 4'b0001 || lat !== 2 || p !== 16'd143) begin
      n_fail++;
      $display("FAIL single_op: got to=%0d rdy=%b rv=%b lat=%0d p=%0d required 0 0001 0001 2 143",
               to, rdy, rv, lat, p);
    end
    n_tests++;
    if (op_count !== 16'(m_ops) || rsp_valid !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got cnt=%0d rv=%b busy=%b required %0d 0000 0",
               op_count, rsp_valid, busy, m_ops);
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  ta [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0]  tb [3] = '{8'd255, 8'd200, 8'd255};
    logic [15:0] tp [3] = '{16'hFE01, 16'h0000, 16'h00FF};
    logic [N-1:0] rdy, rv;
    logic [15:0] p;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      one_op(i + 1, ta[i], tb[i], rdy, rv, p, lat, to);
      m_last = i + 1;
      m_ops++;
      n_tests++;
      if (to || rdy !== onehot(i + 1) || rv !== onehot(i + 1) || p !== tp[i]) begin
        n_fail++;
        $display("FAIL extremes[%0d]: got to=%0d rdy=%b rv=%b p=%h required %b %b %h",
                 i, to, rdy, rv, p, onehot(i + 1), onehot(i + 1), tp[i]);
      end
    end
  endtask

  task automatic test_fairness();
    bit to;
    int g;
    logic [7:0] ea, eb;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_last = N - 1;
    m_ops  = 0;
    for (int r = 0; r < N; r++) set_req(r, 8'($urandom), 8'($urandom));
    req_valid = '1;
    rsp_ready = '1;
    for (int op = 0; op < 8; op++) begin
      wait_grant(to);
      n_tests++;
      if (to || req_ready !== onehot(op % N)) begin
        n_fail++;
        $display("FAIL fair_grant[%0d]: got req_ready=%b required %b", op, req_ready,
                 onehot(op % N));
      end
      g  = op % N;
      ea = req_a[g*8 +: 8];
      eb = req_b[g*8 +: 8];
      m_last = g;
      step();
      set_req(g, 8'($urandom), 8'($urandom));
      for (int c = 0; c < 20 && rsp_valid === '0; c++) step();
      n_tests++;
      if (rsp_valid !== onehot(g) || rsp_p !== 16'(ea) * 16'(eb)) begin
        n_fail++;
        $display("FAIL fair_rsp[%0d]: got rv=%b p=%0d required %b %0d", op, rsp_valid, rsp_p,
                 onehot(g), 16'(ea) * 16'(eb));
      end
      step();
      m_ops++;
    end
    req_valid = '0;
    n_tests++;
    if (op_count !== 16'(m_ops)) begin
      n_fail++;
      $display("FAIL fair_count: got %0d required %0d", op_count, m_ops);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [7:0] a, b;
    logic [15:0] p0;
    int nxt;
    a = 8'($urandom); b = 8'($urandom);
    set_req(1, a, b);
    req_valid = onehot(1);
    rsp_ready = '0;
    wait_grant(to);
    m_last = 1;
    step();
    req_valid = 4'b1101;
    for (int c = 0; c < 20 && rsp_valid === '0; c++) step();
    p0 = rsp_p;
    n_tests++;
    if (rsp_valid !== 4'b0010 || p0 !== 16'(a) * 16'(b)) begin
      n_fail++;
      $display("FAIL bp_rsp: got rv=%b p=%0d required 0010 %0d", rsp_valid, p0,
               16'(a) * 16'(b));
    end
    rsp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if ({rsp_valid, rsp_p, req_ready, busy} !== {4'b0010, p0, 4'b0000, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rv=%b p=%h rdy=%b busy=%b required 0010 %h 0000 1",
                 c, rsp_valid, rsp_p, req_ready, busy, p0);
      end
    end
    rsp_ready = '1;
    step();
    m_ops++;
    nxt = pick(m_last, req_valid);
    n_tests++;
    if (rsp_valid !== '0 || req_ready !== onehot(nxt)) begin
      n_fail++;
      $display("FAIL bp_release: got rv=%b rdy=%b required 0000 %b", rsp_valid, req_ready,
               onehot(nxt));
    end
    m_last = nxt;
    step();
    req_valid = '0;
    for (int c = 0; c < 20 && rsp_valid === '0; c++) step();
    step();
    m_ops++;
    n_tests++;
    if (op_count !== 16'(m_ops)) begin
      n_fail++;
      $display("FAIL bp_count: got %0d required %0d", op_count, m_ops);
    end
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] rdy, rv;
    logic [15:0] p;
    int lat;
    bit to;
    set_req(3, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    req_valid = onehot(3);
    rsp_ready = '1;
    wait_grant(to);
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_last = N - 1;
    m_ops  = 0;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_p, mul_a, mul_b, busy, op_count} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got rdy=%b rv=%b p=%h a=%h b=%h busy=%b cnt=%h required all 0",
               req_ready, rsp_valid, rsp_p, mul_a, mul_b, busy, op_count);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (rsp_valid !== '0) begin
        n_fail++;
        $display("FAIL midop_no_rsp[%0d]: got rv=%b required 0000", c, rsp_valid);
      end
    end
    set_req(2, 8'd7, 8'd9);
    req_valid = 4'b1100;
    #1;
    n_tests++;
    if (req_ready !== onehot(pick(m_last, req_valid))) begin
      n_fail++;
      $display("FAIL midop_regrant: got rdy=%b required %b", req_ready,
               onehot(pick(m_last, req_valid)));
    end
    req_valid = '0;
    one_op(2, 8'd7, 8'd9, rdy, rv, p, lat, to);
    m_last = 2;
    m_ops++;
    n_tests++;
    if (to || p !== 16'd63 || op_count !== 16'(m_ops)) begin
      n_fail++;
      $display("FAIL midop_followup: got to=%0d p=%0d cnt=%0d required 0 63 %0d", to, p,
               op_count, m_ops);
    end
  endtask

  task automatic test_random();
    bit to;
    int g, k;
    logic [7:0] ea, eb;
    for (int op = 0; op < 30; op++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        #1;
        n_tests++;
        if (req_ready !== '0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_idle[%0d]: got rdy=%b busy=%b required 0000 0", op, req_ready, busy);
        end
        step();
      end
      for (int r = 0; r < N; r++) set_req(r, 8'($urandom), 8'($urandom));
      req_valid = 4'($urandom_range(1, 15));
      wait_grant(to);
      g = pick(m_last, req_valid);
      n_tests++;
      if (to || req_ready !== onehot(g)) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: got rdy=%b required %b (valid=%b)", op, req_ready,
                 onehot(g), req_valid);
      end
      ea = req_a[g*8 +: 8];
      eb = req_b[g*8 +: 8];
      m_last = g;
      rsp_ready = 4'($urandom) & ~onehot(g);
      step();
      req_valid = 4'($urandom);
      for (int r = 0; r < N; r++) set_req(r, 8'($urandom), 8'($urandom));
      for (int c = 0; c < 20 && rsp_valid === '0; c++) step();
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        rsp_ready = 4'($urandom) & ~onehot(g);
        step();
      end
      n_tests++;
      if (rsp_valid !== onehot(g) || rsp_p !== 16'(ea) * 16'(eb) || req_ready !== '0) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: got rv=%b p=%0d rdy=%b required %b %0d 0000", op,
                 rsp_valid, rsp_p, req_ready, onehot(g), 16'(ea) * 16'(eb));
      end
      rsp_ready = 4'($urandom) | onehot(g);
      step();
      m_ops++;
      n_tests++;
      if (op_count !== 16'(m_ops) || rsp_valid !== '0) begin
        n_fail++;
        $display("FAIL rnd_count[%0d]: got cnt=%0d rv=%b required %0d 0000", op, op_count,
                 rsp_valid, m_ops);
      end
    end
    req_valid = '0;
    rsp_ready = '1;
  endtask

  task automatic test_lat3();
    logic [7:0] a, b;
    int lat;
    bit moved;
    a = 8'($urandom); b = 8'($urandom);
    d3_req_a[8 +: 8] = a;
    d3_req_b[8 +: 8] = b;
    d3_req_valid = onehot(1);
    d3_rsp_ready = '1;
    #1;
    n_tests++;
    if (d3_req_ready !== onehot(1)) begin
      n_fail++;
      $display("FAIL lat3_grant: got rdy=%b required 0010", d3_req_ready);
    end
    step();
    d3_req_valid = '0;
    d3_req_a = 32'($urandom);
    d3_req_b = 32'($urandom);
    lat = 1;
    moved = 1'b0;
    for (int c = 0; c < 20 && d3_rsp_valid === '0; c++) begin
      if (d3_mul_a !== a || d3_mul_b !== b) moved = 1'b1;
      step();
      lat++;
    end
    n_tests++;
    if (moved || lat !== 4 || d3_rsp_valid !== onehot(1) || d3_rsp_p !== 16'(a) * 16'(b)) begin
      n_fail++;
      $display("FAIL lat3_rsp: got moved=%0d lat=%0d rv=%b p=%0d required 0 4 0010 %0d",
               moved, lat, d3_rsp_valid, d3_rsp_p, 16'(a) * 16'(b));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
